// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Two-client (dcache / icache) arbiter in front of a single    |
// |               block memory. One transaction at a time through an          |
// |               IDLE -> REQ -> WAIT -> RESP sequence; the granted request is |
// |               latched so memory only ever sees stable values.              |
// | Option      : MEM_ARB_ROUND_ROBIN_EN - simultaneous requests alternate     |
// |               between the clients (pointer favours dcache after reset).    |
// |               Undefined: dcache always wins a simultaneous request.        |
// | Ports       : clk, reset (sync, active-high)                               |
// |               d_read/d_write/d_address/d_writedata -> d_readdata,          |
// |                 d_busywait                      (dcache side)              |
// |               i_read/i_address -> i_readdata, i_busywait (icache side)     |
// |               mem_read/mem_write/mem_address/mem_writedata,                |
// |                 mem_readdata/mem_busywait       (memory side)              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;

  logic d_req;
  logic grant_i;
  logic mem_active;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q names the client that wins the next simultaneous request.
  logic rr_q;

  assign grant_i = i_read & (~d_req | (rr_q == OWN_I));

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= OWN_D;
    end else if ((state_q == IDLE) && (d_req | i_read)) begin
      rr_q <= grant_i ? OWN_D : OWN_I;
    end
  end
`else
  assign grant_i = i_read & ~d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_D;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_req | i_read) begin
          state_d = REQ;
          if (grant_i) begin
            owner_d = OWN_I;
            wr_d    = 1'b0;
            addr_d  = i_address;
            wdata_d = '0;
          end else begin
            // read+write together is a write
            owner_d = OWN_D;
            wr_d    = d_write;
            addr_d  = d_address;
            wdata_d = d_writedata;
          end
        end
      end
      REQ: begin
        // memory must acknowledge by raising busywait before we wait for it
        if (mem_busywait) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!mem_busywait) begin
          state_d = RESP;
          if (!wr_q) begin
            if (owner_q == OWN_I) begin
              i_rdata_d = mem_readdata;
            end else begin
              d_rdata_d = mem_readdata;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_active    = (state_q == REQ) || (state_q == WAIT);
  assign mem_read      = mem_active & ~wr_q;
  assign mem_write     = mem_active &  wr_q;
  assign mem_address   = mem_active ? addr_q  : '0;
  assign mem_writedata = mem_active ? wdata_q : '0;

  // A client is released only during the RESP cycle of its own transaction.
  assign d_busywait = d_req  & ~((state_q == RESP) && (owner_q == OWN_D));
  assign i_busywait = i_read & ~((state_q == RESP) && (owner_q == OWN_I));

  assign d_readdata = d_rdata_q;
  assign i_readdata = i_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Self-checking bench for mem_arbiter: directed scenarios,     |
// |               then randomized dcache/icache traffic against a             |
// |               transaction-level reference model and a memory responder.   |
// | Option      : MEM_ARB_ROUND_ROBIN_EN selects the expected grant policy.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata, d_readdata;
  logic              d_busywait;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  logic              mem_busywait;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_readdata   (d_readdata),
    .d_busywait   (d_busywait),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_busywait   (i_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] memarr [64];
  logic [31:0] refmem [64];
  int          mem_lat;
  bit          m_active;
  int          m_cnt;
  logic [5:0]  m_addr;
  bit          m_wr, m_rd, m_new;
  logic [31:0] m_wd;

  // Advance to the next negedge, then act as the memory for that cycle.
  task automatic tick();
    @(negedge clk);
    m_new = 1'b0;
    if (m_active && !(mem_read || mem_write)) begin
      m_active     = 1'b0;
      mem_busywait = 1'b0;
    end else if (!m_active && (mem_read || mem_write)) begin
      m_active     = 1'b1;
      m_cnt        = mem_lat;
      mem_busywait = 1'b1;
      m_addr       = mem_address;
      m_wr         = mem_write;
      m_rd         = mem_read;
      m_wd         = mem_writedata;
      m_new        = 1'b1;
      mem_readdata = $urandom;
    end else if (m_active) begin
      check("mem_hold", {24'd0, mem_read, mem_write, mem_address},
            {24'd0, m_rd, m_wr, m_addr});
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mem_busywait = 1'b0;
          if (m_wr) memarr[m_addr] = m_wd;
          else      mem_readdata   = memarr[m_addr];
        end
      end
    end
  endtask

  function automatic logic bw(input bit is_i);
    return is_i ? i_busywait : d_busywait;
  endfunction

  task automatic wait_done(input bit is_i, input string tag, output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      n++;
      if (!bw(is_i)) break;
    end
    check({tag, "_done"}, {31'd0, bw(is_i)}, 32'd0);
  endtask

  // ---------------- reference model state ----------------
  bit          d_pend, i_pend, d_isw, fav_i, win_i, ok, fi;
  logic [5:0]  d_a, i_a;
  logic [31:0] d_wd, d_exp, i_exp;
  int          d_age, i_age, n, op;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; d_read = 0; d_write = 0; d_address = '0; d_writedata = '0;
    i_read = 0; i_address = '0; mem_readdata = '0; mem_busywait = 1'b0;
    mem_lat = 1; m_active = 0; m_cnt = 0; m_new = 0;
    m_addr = '0; m_wr = 0; m_rd = 0; m_wd = '0;
    for (int k = 0; k < 64; k++) memarr[k] = $urandom;

    // ---- reset state ----
    tick(); tick();
    check("rst_d_rdata", d_readdata, 32'd0);
    check("rst_i_rdata", i_readdata, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_addr", {26'd0, mem_address}, 32'd0);
    check("rst_wdata", mem_writedata, 32'd0);
    reset = 1'b0;
    tick();

    // ---- icache read of 0x05, memory busy 3 cycles ----
    memarr[5] = 32'hA5A5_0001; mem_lat = 3;
    i_read = 1'b1; i_address = 6'h05;
    wait_done(1'b1, "s1", n);
    check("s1_latency", n, 32'd5);
    check("s1_rdata", i_readdata, 32'hA5A5_0001);
    check("s1_addr", {26'd0, m_addr}, 32'h05);
    check("s1_op", {30'd0, m_rd, m_wr}, 32'd2);
    check("s1_d_rdata", d_readdata, 32'd0);
    check("s1_d_busy", {31'd0, d_busywait}, 32'd0);
    tick();
    check("s1_busy_again", {31'd0, i_busywait}, 32'd1);
    i_read = 1'b0;
    tick();
    check("s1_idle_strobe", {31'd0, mem_read}, 32'd0);

    // ---- dcache write 0x12 ----
    mem_lat = 2;
    d_write = 1'b1; d_address = 6'h12; d_writedata = 32'hDEAD_BEEF;
    wait_done(1'b0, "s2", n);
    check("s2_latency", n, 32'd4);
    check("s2_op", {30'd0, m_rd, m_wr}, 32'd1);
    check("s2_wdata", m_wd, 32'hDEAD_BEEF);
    check("s2_addr", {26'd0, m_addr}, 32'h12);
    check("s2_mem", memarr[6'h12], 32'hDEAD_BEEF);
    check("s2_d_rdata", d_readdata, 32'd0);
    d_write = 1'b0;
    tick();
    check("s2_idle", {29'd0, mem_read, mem_write, d_busywait}, 32'd0);
    check("s2_idle_addr", {26'd0, mem_address}, 32'd0);

    // ---- simultaneous d_read / i_read (previous owner is D) ----
    mem_lat = 1;
    memarr[6'h20] = 32'h1111_2222; memarr[6'h21] = 32'h3333_4444;
    fi = RR;
    d_read = 1'b1; d_address = 6'h20; i_read = 1'b1; i_address = 6'h21;
    for (int k = 0; k < 40; k++) begin
      tick();
      check("s3_other_busy", {31'd0, bw(!fi)}, 32'd1);
      if (!bw(fi)) break;
    end
    check("s3_first_done", {31'd0, bw(fi)}, 32'd0);
    check("s3_first_addr", {26'd0, m_addr}, fi ? 32'h21 : 32'h20);
    check("s3_first_data", fi ? i_readdata : d_readdata, fi ? 32'h3333_4444 : 32'h1111_2222);
    if (fi) i_read = 1'b0; else d_read = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n++;
      if (m_new) break;
    end
    check("s3_grant_gap", n, 32'd2);
    check("s3_second_addr", {26'd0, m_addr}, fi ? 32'h20 : 32'h21);
    wait_done(!fi, "s3_second", n);
    check("s3_second_data", fi ? d_readdata : i_readdata, fi ? 32'h1111_2222 : 32'h3333_4444);
    check("s3_first_kept", fi ? i_readdata : d_readdata, fi ? 32'h3333_4444 : 32'h1111_2222);
    d_read = 1'b0; i_read = 1'b0;
    tick();

    // ---- d_read and d_write together at 0x3F, minimum latency ----
    mem_lat = 1;
    d_read = 1'b1; d_write = 1'b1; d_address = 6'h3F; d_writedata = 32'hC0FF_EE11;
    wait_done(1'b0, "s6", n);
    check("s6_latency", n, 32'd3);
    check("s6_op", {30'd0, m_rd, m_wr}, 32'd1);
    check("s6_mem", memarr[6'h3F], 32'hC0FF_EE11);
    d_read = 1'b0; d_write = 1'b0;
    tick();

    // ---- reset during WAIT of a dcache read ----
    mem_lat = 3; memarr[7] = 32'h5A5A_7777;
    d_read = 1'b1; d_address = 6'h07;
    tick(); tick();
    check("s5_in_wait", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    tick();
    check("s5_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("s5_addr", {26'd0, mem_address}, 32'd0);
    check("s5_wdata", mem_writedata, 32'd0);
    check("s5_d_rdata", d_readdata, 32'd0);
    check("s5_i_rdata", i_readdata, 32'd0);
    reset = 1'b0;
    wait_done(1'b0, "s5", n);
    check("s5_rdata", d_readdata, 32'h5A5A_7777);
    d_read = 1'b0;
    tick();

    // ---- randomized traffic against the reference model ----
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 64; k++) refmem[k] = memarr[k];
    d_exp = '0; i_exp = '0; fav_i = 1'b0;
    d_pend = 0; i_pend = 0; d_isw = 0; d_age = 0; i_age = 0;
    d_a = '0; i_a = '0; d_wd = '0;
    for (int c = 0; c < 2000; c++) begin
      mem_lat = $urandom_range(1, 3);
      tick();
      // completions seen by the clients
      if (d_pend && !d_busywait) begin
        if (d_isw) refmem[d_a] = d_wd;
        else       d_exp = refmem[d_a];
        d_pend = 1'b0;
      end
      if (i_pend && !i_busywait) begin
        i_exp  = refmem[i_a];
        i_pend = 1'b0;
      end
      check("d_rdata", d_readdata, d_exp);
      check("i_rdata", i_readdata, i_exp);
      if (!(mem_read || mem_write)) begin
        check("idle_addr", {26'd0, mem_address}, 32'd0);
        check("idle_wdata", mem_writedata, 32'd0);
      end
      // a newly started memory transaction must be the expected winner's
      if (m_new) begin
        win_i = (d_pend && i_pend) ? (RR ? fav_i : 1'b0) : i_pend;
        if (win_i) ok = i_pend && !m_wr && (m_addr == i_a);
        else       ok = d_pend && (m_wr == d_isw) && (m_addr == d_a) && (!d_isw || m_wd == d_wd);
        check("grant", {31'd0, ok}, 32'd1);
        fav_i = !win_i;
      end
      if (d_pend) d_age++;
      if (i_pend) i_age++;
      if (d_age == 100) check("d_stall", {31'd0, d_busywait}, 32'd0);
      if (i_age == 100) check("i_stall", {31'd0, i_busywait}, 32'd0);
      // new stimulus
      if (!d_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          op = $urandom_range(0, 2);
          d_isw = (op != 0);
          d_a = 6'($urandom); d_wd = $urandom;
          d_read = (op != 1); d_write = (op != 0);
          d_address = d_a; d_writedata = d_wd;
          d_pend = 1'b1; d_age = 0;
        end else begin
          d_read = 1'b0; d_write = 1'b0;
          d_address = 6'($urandom); d_writedata = $urandom;
        end
      end
      if (!i_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          i_a = 6'($urandom);
          i_read = 1'b1; i_address = i_a;
          i_pend = 1'b1; i_age = 0;
        end else begin
          i_read = 1'b0; i_address = 6'($urandom);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
